// File: rtl/adc_sched_pkg.sv
// Shared state encoding, widths and helpers for the ADC request scheduler
// and its round-robin arbiter.
package adc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } sched_state_e;

    localparam int TMO_CNT_W = 16;

    // Width of a requester index; never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping
// at NUM_REQ. Reusable by any block sharing a single resource.
module rr_arbiter
    import adc_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = chan_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W:0]       off;
    logic [IDX_W:0]       sum;

    // Rotate so that bit 0 of req_rot corresponds to the pointer position.
    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> ptr);
    assign any_req = |req;

    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = (IDX_W + 1)'(i);
            end
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            winner = IDX_W'(sum - (IDX_W + 1)'(NUM_REQ));
        end else begin
            winner = IDX_W'(sum);
        end
    end

endmodule

// File: rtl/adc_req_scheduler.sv
// Round-robin sharing of one SPI ADC conversion engine among NUM_REQ requesters.
// Optional conversion watchdog enabled by defining ADC_SCHED_TIMEOUT_EN.
module adc_req_scheduler
    import adc_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 12,
    parameter int TIMEOUT_CYC = 255,
    localparam int CHAN_W     = chan_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_err,
    output logic               busy,
    output logic               conv_start,
    output logic [CHAN_W-1:0]  conv_chan,
    input  logic               conv_busy,
    input  logic               conv_done,
    input  logic [DATA_W-1:0]  conv_data
);

    sched_state_e       state_q, state_d;
    logic [CHAN_W-1:0]  chan_q, chan_d;
    logic [CHAN_W-1:0]  ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic [CHAN_W-1:0]  winner;
    logic               any_req;
    logic [NUM_REQ-1:0] chan_onehot;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (CHAN_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign chan_onehot[gi] = (chan_q == CHAN_W'(gi));
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
    logic                 rd_err_q, rd_err_d;
    logic                 tmo_hit;

    // Counter holds the number of completed WAIT cycles; the last one trips it.
    assign tmo_hit = (cnt_q == TMO_CNT_W'(TIMEOUT_CYC - 1));
    assign rd_err  = rd_err_q;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign rd_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        ptr_d     = ptr_q;
        ack_d     = '0;
        rd_data_d = rd_data_q;
        start_d   = 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
        cnt_d     = cnt_q;
        rd_err_d  = rd_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req && !conv_busy) begin
                    chan_d  = winner;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef ADC_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // A requester that has let go of req loses its ack but still frees the slot.
                if (conv_done) begin
                    rd_data_d = conv_data;
                    ack_d     = chan_onehot & req;
                    state_d   = ACK;
`ifdef ADC_SCHED_TIMEOUT_EN
                    rd_err_d  = 1'b0;
                end else if (tmo_hit) begin
                    rd_data_d = '0;
                    rd_err_d  = 1'b1;
                    ack_d     = chan_onehot & req;
                    state_d   = ACK;
                end else begin
                    cnt_d     = cnt_q + TMO_CNT_W'(1);
`endif
                end
            end
            ACK: begin
                ptr_d   = (chan_q == CHAN_W'(NUM_REQ - 1)) ? '0 : chan_q + CHAN_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            chan_q    <= '0;
            ptr_q     <= '0;
            ack_q     <= '0;
            rd_data_q <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
            cnt_q     <= '0;
            rd_err_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            rd_data_q <= rd_data_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
`ifdef ADC_SCHED_TIMEOUT_EN
            cnt_q     <= cnt_d;
            rd_err_q  <= rd_err_d;
`endif
        end
    end

    assign ack        = ack_q;
    assign rd_data    = rd_data_q;
    assign busy       = busy_q;
    assign conv_start = start_q;
    assign conv_chan  = chan_q;

endmodule

// File: tb/tb_adc_req_scheduler.sv
// Scoreboard bench for adc_req_scheduler: directed stimulus queues expected
// starts/acks with their cycle numbers; a monitor pops and compares them.
module tb_adc_req_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 12;
    localparam int CHAN_W  = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_err;
    logic               busy;
    logic               conv_start;
    logic [CHAN_W-1:0]  conv_chan;
    logic               conv_busy;
    logic               conv_done;
    logic [DATA_W-1:0]  conv_data;

    adc_req_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ack        (ack),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .busy       (busy),
        .conv_start (conv_start),
        .conv_chan  (conv_chan),
        .conv_busy  (conv_busy),
        .conv_done  (conv_done),
        .conv_data  (conv_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic [CHAN_W-1:0] chan;
    } start_exp_t;

    typedef struct {
        int                 cyc;
        logic [NUM_REQ-1:0] ack;
        logic [DATA_W-1:0]  data;
        logic               err;
    } ack_exp_t;

    start_exp_t start_exp[$];
    ack_exp_t   ack_exp[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic exp_start(input int c, input int ch);
        start_exp_t x;
        x.cyc  = c;
        x.chan = CHAN_W'(ch);
        start_exp.push_back(x);
    endtask

    task automatic exp_ack(input int c, input logic [NUM_REQ-1:0] a,
                           input logic [DATA_W-1:0] d, input logic e);
        ack_exp_t x;
        x.cyc  = c;
        x.ack  = a;
        x.data = d;
        x.err  = e;
        ack_exp.push_back(x);
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin
        start_exp_t se;
        ack_exp_t   ae;
        logic       busy_prev;
        busy_prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            while (start_exp.size() != 0 && start_exp[0].cyc < cyc) begin
                se = start_exp.pop_front();
                n_tests++;
                n_fail++;
                $display("[TB] FAIL missing_start: got no start, expected chan %0d at cycle %0d", se.chan, se.cyc);
            end
            while (ack_exp.size() != 0 && ack_exp[0].cyc < cyc) begin
                ae = ack_exp.pop_front();
                n_tests++;
                n_fail++;
                $display("[TB] FAIL missing_ack: got no ack, expected %b at cycle %0d", ae.ack, ae.cyc);
            end
            if (conv_start) begin
                $display("[TB] cycle %0d start chan %0d", cyc, conv_chan);
                check("start_while_busy", 32'(busy_prev), 32'd0);
                if (start_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_start: got chan %0d at cycle %0d, expected none", conv_chan, cyc);
                end else begin
                    se = start_exp.pop_front();
                    check("start_cycle", 32'(cyc), 32'(se.cyc));
                    check("start_chan", 32'(conv_chan), 32'(se.chan));
                end
            end
            if (ack != '0) begin
                $display("[TB] cycle %0d ack %b data %h err %b", cyc, ack, rd_data, rd_err);
                if (ack_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_ack: got %b at cycle %0d, expected none", ack, cyc);
                end else begin
                    ae = ack_exp.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(ae.cyc));
                    check("ack_vec", 32'(ack), 32'(ae.ack));
                    check("ack_data", 32'(rd_data), 32'(ae.data));
                    check("ack_err", 32'(rd_err), 32'(ae.err));
                end
            end
            busy_prev = busy;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int s;
        req       = '0;
        conv_busy = 1'b0;
        conv_done = 1'b0;
        conv_data = '0;
        rst_n     = 1'b0;
        step(3);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);
        check("rst_start", 32'(conv_start), 32'd0);
        check("rst_chan", 32'(conv_chan), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step(2);
        check("idle_busy", 32'(busy), 32'd0);

        // All requesters active: grants 0,1,2,3,0 with done 3 cycles after start.
        c   = cyc;
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            s = c + 1 + 6 * k;
            exp_start(s, k % 4);
            exp_ack(s + 4, 4'(1 << (k % 4)), 12'(12'h100 + k), 1'b0);
            goto(s + 3);
            conv_done = 1'b1;
            conv_data = 12'(12'h100 + k);
            step();
            conv_done = 1'b0;
        end
        req = '0;

        // Single request on channel 2.
        step(2);
        c   = cyc;
        req = 4'b0100;
        exp_start(c + 1, 2);
        exp_ack(c + 11, 4'b0100, 12'hABC, 1'b0);
        step();
        check("single_busy_start", 32'(busy), 32'd1);
        goto(c + 10);
        check("single_busy_wait", 32'(busy), 32'd1);
        conv_done = 1'b1;
        conv_data = 12'hABC;
        step();
        conv_done = 1'b0;
        req       = '0;
        check("single_busy_ack", 32'(busy), 32'd1);
        step();
        check("single_busy_after", 32'(busy), 32'd0);
        check("single_data_held", 32'(rd_data), 32'hABC);

        // Front end busy holds off the grant.
        step();
        c         = cyc;
        conv_busy = 1'b1;
        req       = 4'b0001;
        step(5);
        conv_busy = 1'b0;
        check("holdoff_no_busy", 32'(busy), 32'd0);
        exp_start(c + 6, 0);
        exp_ack(c + 9, 4'b0001, 12'h5A5, 1'b0);
        goto(c + 8);
        conv_done = 1'b1;
        conv_data = 12'h5A5;
        step();
        conv_done = 1'b0;
        req       = '0;

        // Requester 1 drops during WAIT: no ack, data still captured, pointer moves to 2.
        step(2);
        c   = cyc;
        req = 4'b0010;
        exp_start(c + 1, 1);
        goto(c + 3);
        req = '0;
        goto(c + 5);
        conv_done = 1'b1;
        conv_data = 12'h777;
        step();
        conv_done = 1'b0;
        check("drop_no_ack", 32'(ack), 32'd0);
        check("drop_rd_data", 32'(rd_data), 32'h777);
        check("drop_busy_ack", 32'(busy), 32'd1);
        step();
        req = 4'b0111;
        exp_start(c + 8, 2);

        // Asynchronous reset in the middle of WAIT.
        goto(c + 10);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_chan", 32'(conv_chan), 32'd0);
        check("arst_rd_data", 32'(rd_data), 32'd0);
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_start", 32'(conv_start), 32'd0);
        req = '0;
        step(2);
        rst_n = 1'b1;
        step();
        conv_done = 1'b1;
        conv_data = 12'hFFF;
        step();
        conv_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stray_no_ack", 32'(ack), 32'd0);
            check("stray_rd_data", 32'(rd_data), 32'd0);
            step();
        end

        // Pointer back at 0 after reset: req 1010 must grant 1.
        c   = cyc;
        req = 4'b1010;
        exp_start(c + 1, 1);
        exp_ack(c + 3, 4'b0010, 12'h123, 1'b0);
        goto(c + 2);
        conv_done = 1'b1;
        conv_data = 12'h123;
        step();
        conv_done = 1'b0;
        req       = '0;

`ifdef ADC_SCHED_TIMEOUT_EN
        // Watchdog of 8 WAIT cycles with no done, then done on the limit cycle.
        step(2);
        c   = cyc;
        req = 4'b0001;
        exp_start(c + 1, 0);
        exp_ack(c + 10, 4'b0001, 12'h000, 1'b1);
        goto(c + 10);
        req = '0;
        step(2);
        c   = cyc;
        req = 4'b0100;
        exp_start(c + 1, 2);
        exp_ack(c + 10, 4'b0100, 12'h3C3, 1'b0);
        goto(c + 9);
        conv_done = 1'b1;
        conv_data = 12'h3C3;
        step();
        conv_done = 1'b0;
        req       = '0;
`endif

        step(4);
        check("start_queue_empty", 32'(start_exp.size()), 32'd0);
        check("ack_queue_empty", 32'(ack_exp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_req_scheduler.md
Name: adc_req_scheduler

Overview:
- Round-robin scheduler that shares the single SPI ADC conversion engine among NUM_REQ requesters.
- Each requester raises a level request. The scheduler picks a winner, drives the channel select, and issues a one-cycle start pulse to the ADC front end.
- It waits for the front end's done pulse, then returns the sample to the winner with a one-cycle ack.
- Sits between the comparison/control logic and the SPI ADC front end.

Parameters:
- NUM_REQ, 4, number of requesters; legal 2..8.
- DATA_W, 12, ADC sample width.
- TIMEOUT_CYC, 255, watchdog limit in clk cycles; used only with ADC_SCHED_TIMEOUT_EN; legal 2..65535.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, NUM_REQ, per-requester level request; held until its ack.
- ack, output, NUM_REQ, one-cycle pulse to the served requester.
- rd_data, output, DATA_W, sample for the acked requester; valid in the ack cycle and held until the next ack.
- rd_err, output, 1, high with ack when the conversion timed out.
- busy, output, 1, high from the start cycle through the ack cycle.
- conv_start, output, 1, one-cycle start pulse to the ADC front end.
- conv_chan, output, CHAN_W, index of the granted requester; stable from the start cycle through the ack cycle.
- conv_busy, input, 1, front end busy.
- conv_done, input, 1, one-cycle conversion-complete pulse.
- conv_data, input, DATA_W, sample; valid when conv_done is high.

CHAN_W = max(1, clog2(NUM_REQ)).

Behaviour:
- Reset (async assert, sync release):
  - Registered outputs: ack=0, rd_data=0, rd_err=0, conv_start=0, conv_chan=0.
  - busy is a registered state decode; during and just after reset it reads 0.
  - state=IDLE, round-robin pointer=0.
- IDLE:
  - Wait until (|req) && !conv_busy.
  - Winner = first set req bit searching upward from the pointer, wrapping at NUM_REQ.
  - Register the winner into conv_chan; go to START.
- START: conv_start=1 for exactly this cycle; busy=1; go to WAIT.
- WAIT:
  - conv_done is sampled only in this state. A done in the START cycle, or in IDLE, is ignored.
  - On conv_done: rd_data<=conv_data, rd_err<=0; go to ACK.
- ACK:
  - ack[conv_chan]=1 for one cycle; pointer <= (conv_chan+1) mod NUM_REQ; go to IDLE.
  - The next grant is possible on the following cycle, giving back-to-back service with no idle gap beyond IDLE.
- Latency:
  - req high in IDLE at cycle N (front end idle) -> conv_start at N+1.
  - conv_done at cycle M -> ack and rd_data at M+1.
- Fairness: a requester that was just served has lowest priority next time. With all requests asserted, grants are 0,1,2,3,0,...
- Requester drops req before ack:
  - The conversion still completes and rd_data updates.
  - ack is suppressed for that requester and the pointer still advances.
- req changes during START/WAIT/ACK: no effect on the current grant.
- Reset mid-conversion: return to IDLE immediately with all outputs at reset values. A later conv_done from the aborted conversion is ignored, because the state is no longer WAIT.

Optional Feature:
- ADC_SCHED_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without conv_done: rd_data<=0, rd_err<=1, go to ACK (ack pulses, pointer advances).
  - conv_done and timeout in the same cycle: conv_done wins, rd_err=0.
- Undefined:
  - No counter; WAIT holds indefinitely.
  - rd_err is tied to 0; the port remains present.

Decomposition:
- Package adc_sched_pkg holds:
  - state enum {IDLE, START, WAIT, ACK} in 2-bit encoding;
  - the CHAN_W helper function;
  - the counter width constant (16).
- Sub-module rr_arbiter: combinational round-robin pick with inputs req and pointer, outputs winner index and any_req. It is parameterised by NUM_REQ and reused by other shared-resource blocks.

Test Plan:
- Single request: req=4'b0100 at cycle 10, conv_done at cycle 20 with conv_data=12'hABC -> conv_start at 11, conv_chan=2, ack=4'b0100 at 21, rd_data=12'hABC, busy high cycles 11-21.
- All requesting (req=4'hF, done 3 cycles after each start) -> grant order 0,1,2,3,0; exactly one ack per conversion; conv_start never high while busy.
- Front end held off: req=4'b0001 with conv_busy=1 for 5 cycles -> no conv_start until the cycle after conv_busy falls.
- Drop request: req[1] deasserted during WAIT -> no ack, rd_data updated, next grant starts the pointer at 2.
- Reset mid-WAIT: assert rst_n=0 asynchronously -> outputs cleared within the same cycle. A stray conv_done after release -> no ack.
- ADC_SCHED_TIMEOUT_EN with TIMEOUT_CYC=8 and conv_done never asserted -> ack with rd_err=1 and rd_data=0 at 8 WAIT cycles plus one. Done and timeout in the same cycle -> rd_err=0.
